// File: rtl/time_keeper_bcd_pkg.sv
// Shared types and helpers for the MM:SS BCD time-keeping core.
package time_keeper_bcd_pkg;

    typedef enum logic [1:0] {RUN, PAUSE, ADJUST} state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
    } bcd_pair;

    // Decimal 0..99 to a BCD digit pair, used to elaborate the MAX parameters.
    function automatic bcd_pair to_bcd(input int unsigned v);
        bcd_pair r;
        r.tens = 4'(v / 10);
        r.ones = 4'(v % 10);
        return r;
    endfunction

endpackage

// File: rtl/time_keeper_bcd_if.sv
// Tick/control inputs and display outputs of the time-keeping core.
interface time_keeper_bcd_if;

    logic       tick_1hz;
    logic       tick_2hz;
    logic       tick_4hz;
    logic       pause_btn;
    logic       adj;
    logic       sel;
    logic [3:0] min_ten;
    logic [3:0] min_one;
    logic [3:0] sec_ten;
    logic [3:0] sec_one;
    logic       blank_min;
    logic       blank_sec;
    logic       paused;

    modport master (
        output tick_1hz, tick_2hz, tick_4hz, pause_btn, adj, sel,
        input  min_ten, min_one, sec_ten, sec_one, blank_min, blank_sec, paused
    );

    modport slave (
        input  tick_1hz, tick_2hz, tick_4hz, pause_btn, adj, sel,
        output min_ten, min_one, sec_ten, sec_one, blank_min, blank_sec, paused
    );

endinterface

// File: rtl/time_keeper_bcd_bcd_pair_counter.sv
// Two-digit BCD counter wrapping from max to 00; wrap is the same-cycle carry out.
module bcd_pair_counter
    import time_keeper_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  bcd_pair    max,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       wrap
);

    bcd_pair r_val;

    // Combinational so a chained counter steps on the same edge as this one.
    assign wrap = inc & (r_val == max);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_val <= '0;
        end else if (inc) begin
            if (r_val == max) begin
                r_val <= '0;
            end else if (r_val.ones == BCD_NINE) begin
                r_val.ones <= 4'd0;
                r_val.tens <= r_val.tens + 4'd1;
            end else begin
                r_val.ones <= r_val.ones + 4'd1;
            end
        end
    end

    assign tens = r_val.tens;
    assign ones = r_val.ones;

endmodule

// File: rtl/time_keeper_bcd.sv
// MM:SS time keeper: pause toggle, 2 Hz field adjust and 4 Hz blink masks.
module time_keeper_bcd
    import time_keeper_bcd_pkg::*;
#(
    parameter int MINUTE_MAX = 59,
    parameter int SECOND_MAX = 59
) (
    input  logic                 clk,
    input  logic                 reset,
    time_keeper_bcd_if.slave     tk
);

    localparam bcd_pair MIN_MAX_BCD = to_bcd(MINUTE_MAX);
    localparam bcd_pair SEC_MAX_BCD = to_bcd(SECOND_MAX);

    logic   r_pause_q;
    logic   r_paused;
    logic   r_phase;
    logic   r_blank_min;
    logic   r_blank_sec;

    state_t w_state;
    logic   w_pause_edge;
    logic   w_phase_nxt;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_wrap;
    logic   w_min_wrap_unused;

    // Mode follows adj immediately; the pause flag seen here is the pre-toggle value.
    always_comb begin
        w_state = RUN;
        if (tk.adj)        w_state = ADJUST;
        else if (r_paused) w_state = PAUSE;
    end

    assign w_pause_edge = tk.pause_btn & ~r_pause_q;
    assign w_phase_nxt  = (w_state == ADJUST) ? (r_phase ^ tk.tick_4hz) : 1'b0;

    assign w_sec_inc = ((w_state == RUN) & tk.tick_1hz) |
                       ((w_state == ADJUST) & tk.sel & tk.tick_2hz);
    assign w_min_inc = ((w_state == RUN) & w_sec_wrap) |
                       ((w_state == ADJUST) & ~tk.sel & tk.tick_2hz);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pause_q   <= 1'b0;
            r_paused    <= 1'b0;
            r_phase     <= 1'b0;
            r_blank_min <= 1'b0;
            r_blank_sec <= 1'b0;
        end else begin
            r_pause_q   <= tk.pause_btn;
            if (w_pause_edge) r_paused <= ~r_paused;
            r_phase     <= w_phase_nxt;
            r_blank_min <= w_phase_nxt & ~tk.sel;
            r_blank_sec <= w_phase_nxt & tk.sel;
        end
    end

    bcd_pair_counter u_sec (
        .clk   (clk),
        .reset (reset),
        .inc   (w_sec_inc),
        .max   (SEC_MAX_BCD),
        .tens  (tk.sec_ten),
        .ones  (tk.sec_one),
        .wrap  (w_sec_wrap)
    );

    bcd_pair_counter u_min (
        .clk   (clk),
        .reset (reset),
        .inc   (w_min_inc),
        .max   (MIN_MAX_BCD),
        .tens  (tk.min_ten),
        .ones  (tk.min_one),
        .wrap  (w_min_wrap_unused)
    );

    assign tk.paused    = r_paused;
    assign tk.blank_min = r_blank_min;
    assign tk.blank_sec = r_blank_sec;

endmodule

// File: tb/tb_time_keeper_bcd.sv
// Directed bench for time_keeper_bcd: counting, carry, pause, adjust, blink, reset.
module tb_time_keeper_bcd;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    time_keeper_bcd_if tk();

    time_keeper_bcd #(.MINUTE_MAX(59), .SECOND_MAX(59)) dut (
        .clk   (clk),
        .reset (reset),
        .tk    (tk)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] digits();
        return {tk.min_ten, tk.min_one, tk.sec_ten, tk.sec_one};
    endfunction

    function automatic logic [15:0] blanks();
        return {14'd0, tk.blank_min, tk.blank_sec};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic t1();
        tk.tick_1hz = 1'b1; step(); tk.tick_1hz = 1'b0;
    endtask

    task automatic t4();
        tk.tick_4hz = 1'b1; step(); tk.tick_4hz = 1'b0;
    endtask

    task automatic adj_steps(input logic s, input int n);
        tk.adj = 1'b1;
        tk.sel = s;
        repeat (n) begin
            tk.tick_2hz = 1'b1; step(); tk.tick_2hz = 1'b0;
        end
    endtask

    initial begin
        tk.tick_1hz = 0; tk.tick_2hz = 0; tk.tick_4hz = 0;
        tk.pause_btn = 0; tk.adj = 0; tk.sel = 0;
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        chk("rst_digits", digits(), 16'h0000);
        chk("rst_blanks", blanks(), 16'h0000);
        chk("rst_paused", {15'd0, tk.paused}, 16'h0000);

        // 61 seconds of counting
        repeat (61) t1();
        chk("run61", digits(), 16'h0101);
        chk("run61_blanks", blanks(), 16'h0000);
        chk("run61_paused", {15'd0, tk.paused}, 16'h0000);

        // full wrap and tens-of-minutes carry
        adj_steps(1'b0, 58);
        adj_steps(1'b1, 58);
        chk("preload5959", digits(), 16'h5959);
        tk.adj = 1'b0; step();
        t1();
        chk("wrap0000", digits(), 16'h0000);
        adj_steps(1'b0, 9);
        adj_steps(1'b1, 59);
        tk.adj = 1'b0; step();
        chk("preload0959", digits(), 16'h0959);
        t1();
        chk("carry1000", digits(), 16'h1000);

        // pause toggle, same-cycle tick uses pre-toggle flag
        tk.pause_btn = 1'b1; step();
        chk("pause_on", {15'd0, tk.paused}, 16'h0001);
        repeat (5) t1();
        chk("pause_hold", digits(), 16'h1000);
        tk.pause_btn = 1'b0; step();
        tk.pause_btn = 1'b1; tk.tick_1hz = 1'b1; step(); tk.tick_1hz = 1'b0;
        chk("unpause_flag", {15'd0, tk.paused}, 16'h0000);
        chk("unpause_tick_ignored", digits(), 16'h1000);
        t1();
        chk("resume", digits(), 16'h1001);
        tk.pause_btn = 1'b0;

        // adjust wraps without cross-field carry
        adj_steps(1'b0, 48);
        adj_steps(1'b1, 29);
        chk("preload5830", digits(), 16'h5830);
        adj_steps(1'b0, 3);
        chk("adj_min_wrap", digits(), 16'h0130);
        adj_steps(1'b1, 28);
        chk("adj_sec58", digits(), 16'h0158);
        adj_steps(1'b1, 3);
        chk("adj_sec_wrap", digits(), 16'h0101);
        t1();
        chk("adj_1hz_ignored", digits(), 16'h0101);
        tk.tick_1hz = 1'b1; tk.tick_2hz = 1'b1; step();
        tk.tick_1hz = 1'b0; tk.tick_2hz = 1'b0;
        chk("adj_both_ticks", digits(), 16'h0102);

        // blink masks {blank_min, blank_sec}
        step();
        chk("blink_idle", blanks(), 16'h0000);
        t4();
        chk("blink_1", blanks(), 16'h0001);
        t4();
        chk("blink_2", blanks(), 16'h0000);
        t4();
        chk("blink_3", blanks(), 16'h0001);
        tk.sel = 1'b0; step();
        chk("blink_sel_min", blanks(), 16'h0002);
        tk.adj = 1'b0; step();
        chk("blink_exit", blanks(), 16'h0000);

        // reset dominates a tick and a pause edge in the same cycle
        adj_steps(1'b0, 11);
        adj_steps(1'b1, 32);
        tk.adj = 1'b0; step();
        chk("preload1234", digits(), 16'h1234);
        reset = 1'b1; tk.tick_1hz = 1'b1; tk.pause_btn = 1'b1; step();
        reset = 1'b0; tk.tick_1hz = 1'b0; tk.pause_btn = 1'b0;
        chk("rst_mid_digits", digits(), 16'h0000);
        chk("rst_mid_paused", {15'd0, tk.paused}, 16'h0000);
        t1();
        chk("rst_then_run", digits(), 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
